// File: rtl/hmm_sample_feeder_if.sv
// Host/recognizer sample path of hmm_sample_feeder: host push handshake in,
// paced sample strobe out.
interface hmm_sample_feeder_if;
  // Handshake: a host push transfers in_data on a rising clk edge where
  // in_valid && in_ready; in_valid is a request only and may drop at any time.
  // write is a one-cycle strobe qualifying x_o, with no back-pressure.
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_o;
  logic        write;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  x_o,
    input  write
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output x_o,
    output write
  );
endinterface

// File: rtl/hmm_sample_feeder.sv
// Buffers host audio samples and replays them to the recognizer at a fixed rate.
// Optional decision counters are built when HMM_FEEDER_RESULT_COUNT_EN is defined.
module hmm_sample_feeder #(
  parameter int DIV        = 3125,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  hmm_sample_feeder_if.slave    bus,
  input  logic                  enable,
  output logic                  underrun,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  result_dv,
  input  logic                  result,
  output logic [15:0]           frame_count,
  output logic [15:0]           word_count
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0]         DIV_LAST = 16'(DIV - 1);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [15:0]           div_cnt;
  logic [15:0]           x_q;
  logic                  write_q;
  logic                  tick;
  logic                  push;
  logic                  pop;

  // in_ready comes from the registered count, so a full FIFO refuses a push
  // even when the same cycle pops.
  assign tick         = enable && (div_cnt == DIV_LAST);
  assign bus.in_ready = (count != FULL);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = tick && (count != '0);
  assign level        = count;
  assign bus.x_o      = x_q;
  assign bus.write    = write_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pacer: held at zero while disabled so the first tick lands DIV cycles
  // after enable rises.
  always_ff @(posedge clk) begin
    if (reset || !enable)        div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      write_q  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      write_q <= pop;
      if (pop) x_q <= mem[rd_ptr];
      if (tick && (count == '0)) underrun <= 1'b1;
    end
  end

`ifdef HMM_FEEDER_RESULT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      word_count  <= '0;
    end else if (result_dv) begin
      if (frame_count != 16'hFFFF)           frame_count <= frame_count + 16'd1;
      if (result && word_count != 16'hFFFF)  word_count  <= word_count + 16'd1;
    end
  end
`else
  logic unused_result;
  assign unused_result = result_dv ^ result;
  assign frame_count   = '0;
  assign word_count    = '0;
`endif

endmodule

// File: tb/tb_hmm_sample_feeder.sv
// Directed bench for hmm_sample_feeder with DIV=4, DEPTH_LOG2=2.
module tb_hmm_sample_feeder;
  localparam int DIV = 4;
  localparam int DL2 = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           underrun;
  logic [DL2:0]   level;
  logic           result_dv;
  logic           result;
  logic [15:0]    frame_count;
  logic [15:0]    word_count;

  int checks = 0;
  int errors = 0;

  hmm_sample_feeder_if bus ();

  hmm_sample_feeder #(.DIV(DIV), .DEPTH_LOG2(DL2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .enable      (enable),
    .underrun    (underrun),
    .level       (level),
    .result_dv   (result_dv),
    .result      (result),
    .frame_count (frame_count),
    .word_count  (word_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one cycle; inputs set afterwards apply to the next cycle and
  // outputs read afterwards reflect the edge just taken.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    enable       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    result_dv    = 1'b0;
    result       = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic push_samples(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [15:0] v [3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      cyc();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (bus.x_o !== 16'h0)      begin errors++; $display("FAIL reset_x_o got %h want 0000", bus.x_o); end
    if (bus.write !== 1'b0)     begin errors++; $display("FAIL reset_write got %b want 0", bus.write); end
    if (underrun !== 1'b0)      begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    if (level !== 3'd0)         begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    if (frame_count !== 16'h0)  begin errors++; $display("FAIL reset_frame_count got %h want 0000", frame_count); end
    if (word_count !== 16'h0)   begin errors++; $display("FAIL reset_word_count got %h want 0000", word_count); end
  endtask

  task automatic test_basic_emit();
    int          wpos[$];
    logic [15:0] exp_q[$];
    do_reset();
    push_samples(16'h0001, 16'h7FFF, 16'h8000);
    checks++;
    if (level !== 3'd3) begin errors++; $display("FAIL basic_level_loaded got %0d want 3", level); end
    exp_q = '{16'h0001, 16'h7FFF, 16'h8000};
    enable = 1'b1;
    // Ticks fall in cycles 4, 8, 12; strobes are observed after those edges.
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (bus.write === 1'b1) begin
        wpos.push_back(k);
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_extra_write at cycle %0d x_o %h want none", k, bus.x_o);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.x_o !== e) begin errors++; $display("FAIL basic_x_o got %h want %h", bus.x_o, e); end
        end
      end
    end
    enable = 1'b0;
    checks += 4;
    if (wpos.size() != 3) begin
      errors++; $display("FAIL basic_write_count got %0d want 3", wpos.size());
    end else if (wpos[0] != 4 || wpos[1] != 8 || wpos[2] != 12) begin
      errors++; $display("FAIL basic_write_spacing got %0d,%0d,%0d want 4,8,12", wpos[0], wpos[1], wpos[2]);
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got %0d left want 0", exp_q.size()); end
    if (level !== 3'd0)    begin errors++; $display("FAIL basic_level_end got %0d want 0", level); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got %b want 0", underrun); end
  endtask

  task automatic test_full_fifo();
    logic        exp_rdy [5];
    logic [15:0] exp_q[$];
    int          nwr;
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1000 + 16'(i);
      cyc();
      checks++;
      if (bus.in_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL full_in_ready push %0d got %b want %b", i + 1, bus.in_ready, exp_rdy[i]);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", level); end
    exp_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    nwr = 0;
    enable = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      if (bus.write === 1'b1) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL full_extra_write x_o %h want none", bus.x_o);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.x_o !== e) begin errors++; $display("FAIL full_x_o got %h want %h", bus.x_o, e); end
        end
      end
    end
    enable = 1'b0;
    checks += 2;
    if (nwr != 4) begin errors++; $display("FAIL full_write_count got %0d want 4", nwr); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_end got %b want 1", bus.in_ready); end
  endtask

  task automatic test_underrun();
    int nwr;
    do_reset();
    enable = 1'b1;
    nwr = 0;
    for (int k = 1; k <= 14; k++) begin
      bus.in_valid = (k == 9);
      bus.in_data  = 16'h1234;
      cyc();
      checks++;
      if (underrun !== (k >= 4)) begin
        errors++; $display("FAIL underrun_flag cycle %0d got %b want %b", k, underrun, (k >= 4));
      end
      if (bus.write === 1'b1) begin
        nwr++;
        checks += 2;
        if (k != 12) begin errors++; $display("FAIL underrun_write_cycle got %0d want 12", k); end
        if (bus.x_o !== 16'h1234) begin errors++; $display("FAIL underrun_x_o got %h want 1234", bus.x_o); end
      end
    end
    bus.in_valid = 1'b0;
    enable = 1'b0;
    checks++;
    if (nwr != 1) begin errors++; $display("FAIL underrun_write_count got %0d want 1", nwr); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    push_samples(16'hAAAA, 16'h5555, 16'h0F0F);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hC3C3;
    cyc();
    bus.in_valid = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) cyc();
    checks += 2;
    if (bus.write !== 1'b1 || bus.x_o !== 16'hAAAA) begin
      errors++; $display("FAIL midrst_first write %b x_o %h want 1 aaaa", bus.write, bus.x_o);
    end
    if (level !== 3'd3) begin errors++; $display("FAIL midrst_level_before got %0d want 3", level); end
    for (int k = 5; k <= 7; k++) cyc();
    reset = 1'b1;   // cycle 8 is a tick cycle
    cyc();
    reset = 1'b0;
    enable = 1'b0;
    checks += 4;
    if (bus.write !== 1'b0)  begin errors++; $display("FAIL midrst_write got %b want 0", bus.write); end
    if (level !== 3'd0)      begin errors++; $display("FAIL midrst_level got %0d want 0", level); end
    if (bus.x_o !== 16'h0)   begin errors++; $display("FAIL midrst_x_o got %h want 0000", bus.x_o); end
    if (underrun !== 1'b0)   begin errors++; $display("FAIL midrst_underrun got %b want 0", underrun); end
  endtask

  task automatic test_decisions();
    logic dv_v  [5];
    logic res_v [5];
    logic [15:0] exp_f;
    logic [15:0] exp_w;
    dv_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    res_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      result_dv = dv_v[i];
      result    = res_v[i];
      cyc();
    end
    result_dv = 1'b0;
    result    = 1'b0;
    cyc();
`ifdef HMM_FEEDER_RESULT_COUNT_EN
    exp_f = 16'd3;
    exp_w = 16'd2;
`else
    exp_f = 16'd0;
    exp_w = 16'd0;
`endif
    checks += 2;
    if (frame_count !== exp_f) begin errors++; $display("FAIL dec_frame_count got %0d want %0d", frame_count, exp_f); end
    if (word_count !== exp_w)  begin errors++; $display("FAIL dec_word_count got %0d want %0d", word_count, exp_w); end
  endtask

  initial begin
    test_reset();
    test_basic_emit();
    test_full_fifo();
    test_underrun();
    test_reset_mid_run();
    test_decisions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hmm_sample_feeder.md
# hmm_sample_feeder

Sample-side driver for the word-spotting recognizer. It buffers 16-bit signed audio samples pushed by a host or test source and replays them to the recognizer's `x_i`/`write` input at a fixed sampling rate. It also counts the recognizer's `result_dv`/`result` decisions. It sits upstream of the recognizer top level and closes the loop on its output, so a whole utterance can be staged and played back deterministically.

## Interface
Parameters:
- `DIV`, default 3125: clock cycles per output sample, e.g. 16 kHz from 50 MHz. Legal range is 2..65535.
- `DEPTH_LOG2`, default 6: FIFO depth is 2^DEPTH_LOG2 entries.

Ports (all synchronous to `clk`):
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  16  signed sample from the host.
- `in_valid`  in  1  host push request.
- `in_ready`  out  1  FIFO not full. A push happens when `in_valid && in_ready`.
- `enable`  in  1  run pacing; when low, no samples are emitted.
- `x_o`  out  16  signed sample to the recognizer `x_i`.
- `write`  out  1  one-cycle strobe to the recognizer `write`.
- `underrun`  out  1  sticky: a pacing tick found the FIFO empty.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `result_dv`  in  1  recognizer decision valid.
- `result`  in  1  recognizer decision (1 = word, 0 = garbage/silence).
- `frame_count`  out  16  number of decisions seen.
- `word_count`  out  16  number of decisions with `result`=1.

## Operation
- FIFO
  - Circular buffer with DEPTH_LOG2-bit read/write pointers and a DEPTH_LOG2+1-bit count.
  - `in_ready` = (count != 2^DEPTH_LOG2), computed from the registered count.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Pacer
  - 16-bit counter `div_cnt`.
  - While `enable`=1, it counts 0..DIV-1 and wraps to 0. Tick = (`enable` && `div_cnt`==DIV-1).
  - While `enable`=0, `div_cnt` is held at 0 and no tick occurs.
- Emit
  - On a tick with count>0: pop the head, register it into `x_o`, and set `write`=1 for exactly one cycle.
  - On a tick with count==0: `write` stays 0, `x_o` holds its last value, and `underrun` is set to 1. `underrun` is cleared only by `reset`.
- Decision counting
  - Each cycle with `result_dv`=1 increments `frame_count`.
  - If `result`=1 in that cycle, `word_count` also increments.
  - Both counters saturate at 0xFFFF.
- Arithmetic: pointers wrap modulo 2^DEPTH_LOG2, and the count never exceeds 2^DEPTH_LOG2. Samples pass through bit-exact with no sign handling.

## Timing
- Reset values: `x_o`=0, `write`=0, `underrun`=0, `level`=0, `in_ready`=1, `frame_count`=0, `word_count`=0, `div_cnt`=0.
- Push latency: a sample accepted at edge t is poppable by a tick evaluated in cycle t+1 or later. A push in the same cycle as a tick on an empty FIFO still causes an underrun.
- Emit latency: tick in cycle n gives `write`=1 and a valid `x_o` in cycle n+1. Strobes are spaced exactly DIV cycles apart while `enable` stays high and data is available.
- The first tick occurs DIV cycles after `enable` rises, counting the rising cycle as cycle 1.
- `enable` dropping in a tick cycle suppresses that tick.
- `level` updates one cycle after a push or pop.
- Reset mid-operation flushes the FIFO, zeroes `div_cnt` and all outputs, and suppresses any strobe that would have appeared in the next cycle.

## Configuration
- `HMM_FEEDER_RESULT_COUNT_EN`, defined: the `frame_count`/`word_count` logic is built as described above.
- `HMM_FEEDER_RESULT_COUNT_EN`, undefined: the counters are removed. `frame_count` and `word_count` are tied to 0, and `result_dv`/`result` are ignored. FIFO and pacing behaviour is unchanged.

## Test plan
All scenarios use `DIV`=4 and `DEPTH_LOG2`=2.
- Basic emit: push 0x0001, 0x7FFF, 0x8000, then raise `enable` → `write` pulses exactly 4 cycles apart with `x_o` = 0x0001, 0x7FFF, 0x8000; `level` returns to 0; `underrun` stays 0.
- Full FIFO: push 5 samples back-to-back with `enable`=0 → `in_ready` goes low after the 4th push; the 5th is dropped; `level`=4; playback emits only the first 4.
- Underrun: `enable`=1 with an empty FIFO for 8 cycles → no `write` pulse; `underrun`=1 from cycle 5 onward; a later push plays normally while `underrun` stays 1.
- Reset mid-run: with 3 samples queued and `enable`=1, assert `reset` in a tick cycle → no `write` in the next cycle; `level`=0 and `x_o`=0 one cycle after reset.
- Decisions (macro defined): drive `result_dv` pulses with `result` = 1, 0, 1 → `frame_count`=3, `word_count`=2. With the macro undefined, both counters read 0.
